analog_spin_sampler: RTL and testbench

// Next-generation spin readout path between the analog macro and digital logic.

---
 rtl/analog_spin_sampler.sv | 235 +++++++++++++++++++++++
 tb/tb_analog_spin_sampler.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/analog_spin_sampler.sv
// analog_spin_sampler
// Spin readout path between an analog macro and digital logic. After a compute-finish
// strobe it waits a programmable settle time, then samples the synchronised spin vector
// N times, majority-votes each bit, and queues the voted word in a first-word-fall-through
// FIFO drained over valid/ready.
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   en_i                   block enable; low aborts any in-flight vote
//   cfg_*_i                settle cycles, samples per vote, sync tap; latched by
//                          cfg_enable_i only while idle_o=1 (also clears sticky flags)
//   cmpt_finish_i          one-cycle analog compute-done strobe
//   spin_i                 asynchronous spin outputs of the analog macro
//   spin_valid_o/ready_i   FIFO drain handshake, spin_o is the FIFO head
//   fifo_count_o           FIFO occupancy
//   overflow_o, miss_o     sticky: word dropped on full FIFO / finish seen while busy
//   idle_o                 FSM idle and FIFO empty
module analog_spin_sampler #(
   parameter int unsigned NUM_SPIN         = 256,
   parameter int unsigned COUNTER_BITWIDTH = 16,
   parameter int unsigned SYNC_PIPE_DEPTH  = 3,
   parameter int unsigned MAX_SAMPLES      = 7,
   parameter int unsigned FIFO_DEPTH       = 4,
   localparam int unsigned SW = $clog2(MAX_SAMPLES + 1),
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1),
   localparam int unsigned YW = $clog2(SYNC_PIPE_DEPTH + 1)
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        en_i,
   input  logic                        cfg_enable_i,
   input  logic [COUNTER_BITWIDTH-1:0] cfg_settle_cycles_i,
   input  logic [SW-1:0]               cfg_sample_num_i,
   input  logic [YW-1:0]               cfg_sync_stages_i,
   input  logic                        cmpt_finish_i,
   input  logic [NUM_SPIN-1:0]         spin_i,
   output logic                        spin_valid_o,
   input  logic                        spin_ready_i,
   output logic [NUM_SPIN-1:0]         spin_o,
   output logic [CW-1:0]               fifo_count_o,
   output logic                        overflow_o,
   output logic                        miss_o,
   output logic                        idle_o
);

   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StSettle = 2'd1;
   localparam logic [1:0] StSample = 2'd2;
   localparam logic [1:0] StPush   = 2'd3;

   logic [1:0]                  state_q, state_d;
   logic [COUNTER_BITWIDTH-1:0] settle_cnt_q, settle_cnt_d;
   logic [SW-1:0]               samp_idx_q, samp_idx_d;
   logic [SW-1:0]               vote_cnt_q [NUM_SPIN];
   logic [SW-1:0]               vote_cnt_d [NUM_SPIN];
   logic [NUM_SPIN-1:0]         sync_q [SYNC_PIPE_DEPTH];
   logic [NUM_SPIN-1:0]         sync_d [SYNC_PIPE_DEPTH];
   logic [NUM_SPIN-1:0]         taps [SYNC_PIPE_DEPTH+1];
   logic [NUM_SPIN-1:0]         sampled;
   logic [NUM_SPIN-1:0]         voted;

   logic [COUNTER_BITWIDTH-1:0] cfg_settle_q, cfg_settle_d;
   logic [SW-1:0]               cfg_samples_q, cfg_samples_d, samples_clamped;
   logic [YW-1:0]               cfg_sync_q, cfg_sync_d, sync_clamped;

   logic [NUM_SPIN-1:0]         mem_q [FIFO_DEPTH];
   logic [NUM_SPIN-1:0]         mem_d [FIFO_DEPTH];
   logic [PW-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]               count_q, count_d;
   logic                        overflow_q, overflow_d, miss_q, miss_d;

   logic push_req, push_ok, pop, full, ovf_evt, idle, cfg_load;

   // Sync chain; tap 0 is the raw input, tap k is after k flops.
   always_comb begin
      sync_d[0] = spin_i;
      for (int k = 1; k < SYNC_PIPE_DEPTH; k++) sync_d[k] = sync_q[k-1];
      taps[0] = spin_i;
      for (int k = 1; k <= SYNC_PIPE_DEPTH; k++) taps[k] = sync_q[k-1];
      sampled = taps[cfg_sync_q];
   end

   // Configuration clamping and load.
   always_comb begin
      samples_clamped = cfg_sample_num_i;
      if (cfg_sample_num_i == '0) begin
         samples_clamped = SW'(1);
      end else if (int'(cfg_sample_num_i) > int'(MAX_SAMPLES)) begin
         samples_clamped = SW'(MAX_SAMPLES);
      end
      sync_clamped = cfg_sync_stages_i;
      if (int'(cfg_sync_stages_i) > int'(SYNC_PIPE_DEPTH)) sync_clamped = YW'(SYNC_PIPE_DEPTH);

      idle     = (state_q == StIdle) && (count_q == '0);
      cfg_load = cfg_enable_i && idle;

      cfg_settle_d  = cfg_settle_q;
      cfg_samples_d = cfg_samples_q;
      cfg_sync_d    = cfg_sync_q;
      if (cfg_load) begin
         cfg_settle_d  = cfg_settle_cycles_i;
         cfg_samples_d = samples_clamped;
         cfg_sync_d    = sync_clamped;
      end
   end

   // Majority: strictly more than half the samples were 1; even-N ties give 0.
   always_comb begin
      for (int i = 0; i < NUM_SPIN; i++) begin
         voted[i] = {vote_cnt_q[i], 1'b0} > {1'b0, cfg_samples_q};
      end
   end

   // Readout FSM.
   always_comb begin
      state_d      = state_q;
      settle_cnt_d = settle_cnt_q;
      samp_idx_d   = samp_idx_q;
      vote_cnt_d   = vote_cnt_q;
      push_req     = 1'b0;
      if (!en_i) begin
         // Abort: the partially accumulated word is discarded.
         state_d      = StIdle;
         settle_cnt_d = '0;
         samp_idx_d   = '0;
         for (int i = 0; i < NUM_SPIN; i++) vote_cnt_d[i] = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (cmpt_finish_i) begin
                  if (cfg_settle_q == '0) begin
                     state_d = StSample;
                  end else begin
                     state_d      = StSettle;
                     settle_cnt_d = cfg_settle_q;
                  end
               end
            end
            StSettle: begin
               settle_cnt_d = settle_cnt_q - COUNTER_BITWIDTH'(1);
               if (settle_cnt_q == COUNTER_BITWIDTH'(1)) state_d = StSample;
            end
            StSample: begin
               for (int i = 0; i < NUM_SPIN; i++) begin
                  vote_cnt_d[i] = vote_cnt_q[i] + SW'(sampled[i]);
               end
               if (samp_idx_q == cfg_samples_q - SW'(1)) begin
                  state_d    = StPush;
                  samp_idx_d = '0;
               end else begin
                  samp_idx_d = samp_idx_q + SW'(1);
               end
            end
            StPush: begin
               push_req = 1'b1;
               state_d  = StIdle;
               for (int i = 0; i < NUM_SPIN; i++) vote_cnt_d[i] = '0;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // FIFO; a pop in the PUSH cycle frees the slot the full FIFO needs.
   always_comb begin
      pop      = (count_q != '0) && spin_ready_i;
      full     = (count_q == CW'(FIFO_DEPTH));
      push_ok  = push_req && (!full || pop);
      ovf_evt  = push_req && full && !pop;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = voted;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_ok, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      overflow_d = overflow_q || ovf_evt;
      miss_d     = miss_q || (cmpt_finish_i && (state_q != StIdle));
      if (cfg_load) begin
         overflow_d = 1'b0;
         miss_d     = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= StIdle;
         settle_cnt_q  <= '0;
         samp_idx_q    <= '0;
         cfg_settle_q  <= '0;
         cfg_samples_q <= SW'(1);
         cfg_sync_q    <= YW'(SYNC_PIPE_DEPTH);
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         overflow_q    <= 1'b0;
         miss_q        <= 1'b0;
         for (int i = 0; i < NUM_SPIN; i++) vote_cnt_q[i] <= '0;
         for (int k = 0; k < SYNC_PIPE_DEPTH; k++) sync_q[k] <= '0;
         for (int k = 0; k < FIFO_DEPTH; k++) mem_q[k] <= '0;
      end else begin
         state_q       <= state_d;
         settle_cnt_q  <= settle_cnt_d;
         samp_idx_q    <= samp_idx_d;
         cfg_settle_q  <= cfg_settle_d;
         cfg_samples_q <= cfg_samples_d;
         cfg_sync_q    <= cfg_sync_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         overflow_q    <= overflow_d;
         miss_q        <= miss_d;
         vote_cnt_q    <= vote_cnt_d;
         sync_q        <= sync_d;
         mem_q         <= mem_d;
      end
   end

   assign spin_valid_o = (count_q != '0);
   assign spin_o       = mem_q[rd_ptr_q];
   assign fifo_count_o = count_q;
   assign overflow_o   = overflow_q;
   assign miss_o       = miss_q;
   assign idle_o       = idle;

endmodule

// File: tb/tb_analog_spin_sampler.sv
// tb_analog_spin_sampler
// Self-checking bench for analog_spin_sampler: a table of steady-input vote runs plus
// hand-written sequences for majority patterns, overflow, full-FIFO pop, miss, abort and
// asynchronous reset. Expected words go through a scoreboard queue.
module tb_analog_spin_sampler;

   localparam int NS = 256;
   localparam int SW = 3;
   localparam int CW = 3;
   localparam int YW = 2;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          en_i = 1'b1;
   logic          cfg_enable_i = 1'b0;
   logic [15:0]   cfg_settle_cycles_i = '0;
   logic [SW-1:0] cfg_sample_num_i = '0;
   logic [YW-1:0] cfg_sync_stages_i = '0;
   logic          cmpt_finish_i = 1'b0;
   logic [NS-1:0] spin_i = '0;
   logic          spin_valid_o;
   logic          spin_ready_i = 1'b0;
   logic [NS-1:0] spin_o;
   logic [CW-1:0] fifo_count_o;
   logic          overflow_o, miss_o, idle_o;

   analog_spin_sampler dut (
      .clk_i               (clk_i),
      .rst_i               (rst_i),
      .en_i                (en_i),
      .cfg_enable_i        (cfg_enable_i),
      .cfg_settle_cycles_i (cfg_settle_cycles_i),
      .cfg_sample_num_i    (cfg_sample_num_i),
      .cfg_sync_stages_i   (cfg_sync_stages_i),
      .cmpt_finish_i       (cmpt_finish_i),
      .spin_i              (spin_i),
      .spin_valid_o        (spin_valid_o),
      .spin_ready_i        (spin_ready_i),
      .spin_o              (spin_o),
      .fifo_count_o        (fifo_count_o),
      .overflow_o          (overflow_o),
      .miss_o              (miss_o),
      .idle_o              (idle_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [15:0]   settle;
      logic [SW-1:0] samples;
      logic [YW-1:0] sync;
      logic [NS-1:0] spin;
      int            lat;
   } vec_t;

   vec_t          vecs [5];
   logic [NS-1:0] sb [$];
   int            n_checks = 0;
   int            n_pass = 0;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string name, input logic [NS-1:0] act, input logic [NS-1:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else n_pass++;
   endtask

   task automatic configure(input int s, input int n, input int y);
      cfg_settle_cycles_i = 16'(s);
      cfg_sample_num_i    = SW'(n);
      cfg_sync_stages_i   = YW'(y);
      cfg_enable_i        = 1'b1;
      tick();
      cfg_enable_i = 1'b0;
   endtask

   task automatic pulse_finish();
      cmpt_finish_i = 1'b1;
      tick();
      cmpt_finish_i = 1'b0;
   endtask

   // Pulses finish in the current cycle and returns the cycle offset at which valid rose.
   task automatic finish_and_time(output int lat);
      pulse_finish();
      lat = 1;
      while (!spin_valid_o && lat < 200) begin
         tick();
         lat++;
      end
   endtask

   // Waits (bounded) for a head word, compares it with the scoreboard front, pops it.
   task automatic pop_check(input string name);
      int            n;
      logic [NS-1:0] exp;
      n = 0;
      while (!spin_valid_o && n < 100) begin
         tick();
         n++;
      end
      check({name, "_valid"}, NS'(spin_valid_o), NS'(1));
      exp = (sb.size() > 0) ? sb.pop_front() : 'x;
      check({name, "_word"}, spin_o, exp);
      spin_ready_i = 1'b1;
      tick();
      spin_ready_i = 1'b0;
   endtask

   // Finish with raw sampling and settle 0: sample k sees p[k].
   task automatic run_window(input int n, input logic [NS-1:0] p [4], input logic [NS-1:0] exp,
                             input string name);
      spin_i = '0;
      pulse_finish();
      for (int i = 0; i < n; i++) begin
         spin_i = p[i];
         tick();
      end
      spin_i = '0;
      sb.push_back(exp);
      pop_check(name);
   endtask

   task automatic produce(input logic [NS-1:0] w, input bit expect_kept);
      spin_i = w;
      repeat (5) tick();
      pulse_finish();
      repeat (19) tick();
      if (expect_kept) sb.push_back(w);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int            lat;
      logic [NS-1:0] pat [4];

      vecs[0] = '{16'd2, 3'd3, 2'd2, 256'hA5, 7};
      vecs[1] = '{16'd0, 3'd1, 2'd0, {8{32'h3C3C_0F0F}}, 3};
      vecs[2] = '{16'd5, 3'd0, 2'd3, {NS{1'b1}}, 8};
      vecs[3] = '{16'd1, 3'd7, 2'd1, {8{32'h1234_5678}}, 10};
      vecs[4] = '{16'd3, 3'd4, 2'd3, {4{64'hF0F0_0000_FFFF_0F0F}}, 9};

      repeat (2) @(posedge clk_i);
      #1;
      check("rst_valid", NS'(spin_valid_o), NS'(0));
      check("rst_spin", spin_o, '0);
      check("rst_count", NS'(fifo_count_o), NS'(0));
      check("rst_overflow", NS'(overflow_o), NS'(0));
      check("rst_miss", NS'(miss_o), NS'(0));
      check("rst_idle", NS'(idle_o), NS'(1));
      rst_i = 1'b0;
      tick();

      // Reset config: settle 0, one sample.
      spin_i = 256'h77;
      repeat (5) tick();
      sb.push_back(256'h77);
      finish_and_time(lat);
      check("rst_cfg_latency", NS'(lat), NS'(3));
      pop_check("rst_cfg");

      foreach (vecs[r]) begin
         configure(int'(vecs[r].settle), int'(vecs[r].samples), int'(vecs[r].sync));
         spin_i = vecs[r].spin;
         repeat (5) tick();
         sb.push_back(vecs[r].spin);
         finish_and_time(lat);
         check($sformatf("vec%0d_latency", r), NS'(lat), NS'(vecs[r].lat));
         pop_check($sformatf("vec%0d", r));
         check($sformatf("vec%0d_valid_after_pop", r), NS'(spin_valid_o), NS'(0));
      end

      // Majority: bit0 1,0,1 -> 1; bit1 1,0,0 -> 0; bit2 0,1,1 -> 1.
      configure(0, 3, 0);
      pat[0] = 256'h3; pat[1] = 256'h4; pat[2] = 256'h5; pat[3] = '0;
      run_window(3, pat, 256'h5, "maj3");
      // Four samples: bit0 1,0,1,0 tie -> 0; bit1 1,1,1,0 -> 1.
      configure(0, 4, 0);
      pat[0] = 256'h3; pat[1] = 256'h2; pat[2] = 256'h3; pat[3] = 256'h0;
      run_window(4, pat, 256'h2, "maj4_tie");

      // Overflow: five words into a depth-4 FIFO with no drain.
      configure(2, 3, 2);
      for (int k = 0; k < 5; k++) produce({8{32'h1111_0000 + 32'(k)}}, k < 4);
      check("ovf_count", NS'(fifo_count_o), NS'(4));
      check("ovf_flag", NS'(overflow_o), NS'(1));
      check("ovf_idle", NS'(idle_o), NS'(0));
      for (int k = 0; k < 4; k++) pop_check($sformatf("ovf_drain%0d", k));
      check("ovf_drained_count", NS'(fifo_count_o), NS'(0));
      configure(2, 3, 2);
      check("ovf_cleared", NS'(overflow_o), NS'(0));

      // Full FIFO with a pop in the PUSH cycle: the word is accepted.
      for (int k = 0; k < 4; k++) produce({8{32'h2222_0000 + 32'(k)}}, 1'b1);
      spin_i = {8{32'h2222_0004}};
      repeat (5) tick();
      pulse_finish();
      repeat (5) tick();
      check("fullpop_head", spin_o, sb.pop_front());
      spin_ready_i = 1'b1;
      tick();
      spin_ready_i = 1'b0;
      sb.push_back({8{32'h2222_0004}});
      check("fullpop_count", NS'(fifo_count_o), NS'(4));
      check("fullpop_overflow", NS'(overflow_o), NS'(0));
      for (int k = 0; k < 4; k++) pop_check($sformatf("fullpop_drain%0d", k));

      // Second finish during SAMPLE is a miss and yields only one word.
      configure(2, 3, 2);
      spin_i = 256'hBEEF;
      repeat (5) tick();
      pulse_finish();
      repeat (3) tick();
      pulse_finish();
      sb.push_back(256'hBEEF);
      repeat (20) tick();
      check("miss_flag", NS'(miss_o), NS'(1));
      check("miss_count", NS'(fifo_count_o), NS'(1));
      pop_check("miss_word");
      configure(2, 3, 2);
      check("miss_cleared", NS'(miss_o), NS'(0));

      // Enable dropped during SETTLE: vote aborted.
      configure(5, 3, 2);
      pulse_finish();
      tick();
      en_i = 1'b0;
      tick();
      tick();
      check("abort_idle", NS'(idle_o), NS'(1));
      en_i = 1'b1;
      repeat (20) tick();
      check("abort_count", NS'(fifo_count_o), NS'(0));
      check("abort_valid", NS'(spin_valid_o), NS'(0));

      // Asynchronous reset with two words queued.
      configure(0, 1, 2);
      produce(256'hC001, 1'b1);
      produce(256'hC002, 1'b1);
      check("prerst_count", NS'(fifo_count_o), NS'(2));
      #2 rst_i = 1'b1;
      #1;
      check("async_rst_count", NS'(fifo_count_o), NS'(0));
      check("async_rst_valid", NS'(spin_valid_o), NS'(0));
      check("async_rst_spin", spin_o, '0);
      sb.delete();
      #1 rst_i = 1'b0;
      tick();
      spin_i = 256'h99;
      repeat (5) tick();
      sb.push_back(256'h99);
      finish_and_time(lat);
      check("postrst_latency", NS'(lat), NS'(3));
      pop_check("postrst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
